// File: rtl/spi_rx_pack_buf.sv
// Packet buffer between an Ethernet UDP client and an SPI slave: fills one packet,
// holds it for the slave to read byte by byte, then releases it for the next one.
module spi_rx_pack_buf #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          eth_strobe,
  input  logic [7:0]    eth_data,
  input  logic          eth_start,
  input  logic          eth_commit,
  input  logic          eth_abort,
  output logic          pack_read_ready,
  output logic [AW-1:0] input_packet_len,
  input  logic          pack_read_strobe,
  output logic [7:0]    pack_data_in,
  input  logic          pack_read_done,
  output logic [7:0]    drop_count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]    state, state_n;
  logic [AW-1:0] wr_addr, wr_addr_n;
  logic [AW-1:0] rd_addr, rd_addr_n;
  logic [AW-1:0] len_n;
  logic          ovf, ovf_n;
  logic          drop;
  logic          we;
  logic [AW-1:0] wa;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_p1;
  logic          oor_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_n   = state;
    wr_addr_n = wr_addr;
    rd_addr_n = rd_addr;
    len_n     = input_packet_len;
    ovf_n     = ovf;
    drop      = 1'b0;
    we        = 1'b0;
    wa        = wr_addr;
    case (state)
      IDLE: begin
        if (eth_strobe && eth_start) begin
          we        = 1'b1;
          wa        = '0;
          wr_addr_n = ADDR_ONE;
          ovf_n     = 1'b0;
          state_n   = FILL;
        end
      end
      FILL: begin
        if (eth_strobe && eth_start) begin
          we        = 1'b1;
          wa        = '0;
          wr_addr_n = ADDR_ONE;
          ovf_n     = 1'b0;
          drop      = 1'b1;
        end else if (eth_abort) begin
          state_n = IDLE;
          drop    = 1'b1;
        end else begin
          // The last address is never written so the length always fits in AW bits.
          if (eth_strobe) begin
            if (ovf || wr_addr == '1) begin
              ovf_n = 1'b1;
            end else begin
              we        = 1'b1;
              wr_addr_n = wr_addr + ADDR_ONE;
            end
          end
          if (eth_commit) begin
            if (ovf_n) begin
              state_n = IDLE;
              drop    = 1'b1;
            end else if (wr_addr_n != '0) begin
              len_n     = wr_addr_n;
              rd_addr_n = '0;
              state_n   = READY;
            end
          end
        end
      end
      READY: begin
        if (eth_strobe && eth_start) drop = 1'b1;
        if (pack_read_done) begin
          state_n   = IDLE;
          rd_addr_n = '0;
        end else if (pack_read_strobe) begin
          rd_addr_n = rd_addr + ADDR_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pack_read_ready  <= 1'b0;
      input_packet_len <= '0;
      rd_addr          <= '0;
      wr_addr          <= '0;
      ovf              <= 1'b0;
      drop_count       <= 8'h00;
      oor_p1           <= 1'b1;
    end else begin
      state            <= state_n;
      pack_read_ready  <= (state_n == READY);
      input_packet_len <= len_n;
      rd_addr          <= rd_addr_n;
      wr_addr          <= wr_addr_n;
      ovf              <= ovf_n;
      if (drop) drop_count <= sat_inc(drop_count);
      oor_p1           <= (rd_addr >= input_packet_len);
    end
  end

  // Read stage p1: registered block-RAM read, bytes past the packet end read as zero.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= eth_data;
    rd_data_p1 <= mem[rd_addr];
  end

  assign pack_data_in = oor_p1 ? 8'h00 : rd_data_p1;

endmodule

// File: tb/tb_spi_rx_pack_buf.sv
// Directed bench for spi_rx_pack_buf: cycle table for the basic flows, hand sequences for
// overflow, long packets with read wrap, done/start collision, reset and drop saturation.
module tb_spi_rx_pack_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       eth_strobe, eth_start, eth_commit, eth_abort;
  logic [7:0] eth_data;
  logic       pack_read_ready;
  logic [8:0] input_packet_len;
  logic       pack_read_strobe, pack_read_done;
  logic [7:0] pack_data_in;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;

  // control bits: {strobe, start, commit, abort, read_strobe, read_done}
  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] SS = 6'b110000;
  localparam logic [5:0] S  = 6'b100000;
  localparam logic [5:0] CM = 6'b001000;
  localparam logic [5:0] AB = 6'b000100;
  localparam logic [5:0] RS = 6'b000010;
  localparam logic [5:0] RD = 6'b000001;

  typedef struct {
    logic [5:0] ctl;
    logic [7:0] d;
    logic       rdy;
    logic [8:0] len;
    logic [7:0] drop;
    logic       chkd;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[$];

  spi_rx_pack_buf #(.AW(9)) dut (
    .clk              (clk),
    .rst              (rst),
    .eth_strobe       (eth_strobe),
    .eth_data         (eth_data),
    .eth_start        (eth_start),
    .eth_commit       (eth_commit),
    .eth_abort        (eth_abort),
    .pack_read_ready  (pack_read_ready),
    .input_packet_len (input_packet_len),
    .pack_read_strobe (pack_read_strobe),
    .pack_data_in     (pack_data_in),
    .pack_read_done   (pack_read_done),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] c, input logic [7:0] d);
    {eth_strobe, eth_start, eth_commit, eth_abort, pack_read_strobe, pack_read_done} = c;
    eth_data = d;
    @(posedge clk);
    #1;
    {eth_strobe, eth_start, eth_commit, eth_abort, pack_read_strobe, pack_read_done} = NO;
    eth_data = 8'h00;
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    {eth_strobe, eth_start, eth_commit, eth_abort, pack_read_strobe, pack_read_done} = NO;
    eth_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_ready", 32'(pack_read_ready), 32'd0);
    check("reset_len",   32'(input_packet_len), 32'd0);
    check("reset_drop",  32'(drop_count), 32'd0);
    check("reset_data",  32'(pack_data_in), 32'd0);
    rst = 1'b0;

    tbl.push_back('{SS, 8'h11, 1'b0, 9'd0, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{S,  8'h22, 1'b0, 9'd0, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{S,  8'h33, 1'b0, 9'd0, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{S,  8'h44, 1'b0, 9'd0, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{CM, 8'h00, 1'b1, 9'd4, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h11});
    tbl.push_back('{RS, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h11});
    tbl.push_back('{RS, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h22});
    tbl.push_back('{RS, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h33});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h44});
    tbl.push_back('{RS, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h44});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd4, 8'd0, 1'b1, 8'h00});
    tbl.push_back('{RD, 8'h00, 1'b0, 9'd4, 8'd0, 1'b1, 8'h00});
    tbl.push_back('{SS, 8'hAA, 1'b0, 9'd4, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{S,  8'hBB, 1'b0, 9'd4, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{CM, 8'h00, 1'b1, 9'd2, 8'd0, 1'b0, 8'h00});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd2, 8'd0, 1'b1, 8'hAA});
    tbl.push_back('{SS, 8'h55, 1'b1, 9'd2, 8'd1, 1'b1, 8'hAA});
    tbl.push_back('{S,  8'h66, 1'b1, 9'd2, 8'd1, 1'b1, 8'hAA});
    tbl.push_back('{CM, 8'h00, 1'b1, 9'd2, 8'd1, 1'b1, 8'hAA});
    tbl.push_back('{AB, 8'h00, 1'b1, 9'd2, 8'd1, 1'b1, 8'hAA});
    tbl.push_back('{RS, 8'h00, 1'b1, 9'd2, 8'd1, 1'b1, 8'hAA});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd2, 8'd1, 1'b1, 8'hBB});
    tbl.push_back('{RS, 8'h00, 1'b1, 9'd2, 8'd1, 1'b1, 8'hBB});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd2, 8'd1, 1'b1, 8'h00});
    tbl.push_back('{RD, 8'h00, 1'b0, 9'd2, 8'd1, 1'b1, 8'h00});
    tbl.push_back('{S,  8'h77, 1'b0, 9'd2, 8'd1, 1'b0, 8'h00});
    tbl.push_back('{CM, 8'h00, 1'b0, 9'd2, 8'd1, 1'b0, 8'h00});
    tbl.push_back('{AB, 8'h00, 1'b0, 9'd2, 8'd1, 1'b0, 8'h00});
    tbl.push_back('{SS, 8'h01, 1'b0, 9'd2, 8'd1, 1'b0, 8'h00});
    tbl.push_back('{AB, 8'h00, 1'b0, 9'd2, 8'd2, 1'b0, 8'h00});
    tbl.push_back('{CM, 8'h00, 1'b0, 9'd2, 8'd2, 1'b0, 8'h00});
    tbl.push_back('{SS, 8'h02, 1'b0, 9'd2, 8'd2, 1'b0, 8'h00});
    tbl.push_back('{SS, 8'h03, 1'b0, 9'd2, 8'd3, 1'b0, 8'h00});
    tbl.push_back('{CM, 8'h00, 1'b1, 9'd1, 8'd3, 1'b0, 8'h00});
    tbl.push_back('{NO, 8'h00, 1'b1, 9'd1, 8'd3, 1'b1, 8'h03});
    tbl.push_back('{RD, 8'h00, 1'b0, 9'd1, 8'd3, 1'b0, 8'h00});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].ctl, tbl[i].d);
      check($sformatf("row%0d_ready", i), 32'(pack_read_ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d_len", i),   32'(input_packet_len), 32'(tbl[i].len));
      check($sformatf("row%0d_drop", i),  32'(drop_count), 32'(tbl[i].drop));
      if (tbl[i].chkd) check($sformatf("row%0d_data", i), 32'(pack_data_in), 32'(tbl[i].data));
    end

    // 512-byte packet overflows and is dropped on commit
    step(SS, 8'h00);
    for (int i = 1; i < 512; i++) begin
      b = 8'(i);
      step(S, b);
    end
    step(CM, 8'h00);
    check("ovf512_ready", 32'(pack_read_ready), 32'd0);
    check("ovf512_drop",  32'(drop_count), 32'd4);

    // byte and commit in the same cycle: byte is part of the packet
    step(SS, 8'hC1);
    step(S | CM, 8'hC2);
    check("samecyc_ready", 32'(pack_read_ready), 32'd1);
    check("samecyc_len",   32'(input_packet_len), 32'd2);
    step(NO, 8'h00);
    check("samecyc_d0", 32'(pack_data_in), 32'hC1);
    step(RS, 8'h00);
    step(NO, 8'h00);
    check("samecyc_d1", 32'(pack_data_in), 32'hC2);
    step(RD, 8'h00);
    check("samecyc_release", 32'(pack_read_ready), 32'd0);

    // largest packet (511 bytes), read to the end and past the address wrap
    step(SS, 8'h01);
    for (int i = 1; i < 511; i++) begin
      b = 8'(i + 1);
      step(S, b);
    end
    step(CM, 8'h00);
    check("max_ready", 32'(pack_read_ready), 32'd1);
    check("max_len",   32'(input_packet_len), 32'd511);
    check("max_drop",  32'(drop_count), 32'd4);
    step(NO, 8'h00);
    check("max_d0", 32'(pack_data_in), 32'h01);
    for (int i = 0; i < 510; i++) step(RS, 8'h00);
    step(NO, 8'h00);
    check("max_d510", 32'(pack_data_in), 32'hFF);
    step(RS, 8'h00);
    step(NO, 8'h00);
    check("max_past_end", 32'(pack_data_in), 32'h00);
    step(RS, 8'h00);
    step(NO, 8'h00);
    check("max_wrap", 32'(pack_data_in), 32'h01);
    step(RD, 8'h00);
    check("max_release", 32'(pack_read_ready), 32'd0);

    // done and a new start in the same READY cycle
    step(SS, 8'hD1);
    step(CM, 8'h00);
    check("collide_held", 32'(pack_read_ready), 32'd1);
    step(SS | RD, 8'hE1);
    check("collide_ready", 32'(pack_read_ready), 32'd0);
    check("collide_drop",  32'(drop_count), 32'd5);
    step(S | CM, 8'hE2);
    check("collide_idle",  32'(pack_read_ready), 32'd0);
    check("collide_drop2", 32'(drop_count), 32'd5);

    // reset in the middle of a packet
    step(SS, 8'h99);
    step(S, 8'h98);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", 32'(pack_read_ready), 32'd0);
    check("rst_len",   32'(input_packet_len), 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);
    check("rst_data",  32'(pack_data_in), 32'd0);
    step(CM, 8'h00);
    check("rst_commit_ignored", 32'(pack_read_ready), 32'd0);
    check("rst_commit_drop",    32'(drop_count), 32'd0);

    // drop counter saturation
    for (int i = 0; i < 254; i++) begin
      step(SS, 8'h10);
      step(AB, 8'h00);
    end
    check("sat_254", 32'(drop_count), 32'hFE);
    for (int i = 0; i < 6; i++) begin
      step(SS, 8'h10);
      step(AB, 8'h00);
    end
    check("sat_hold", 32'(drop_count), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_pack_buf.md
SPI_RX_PACK_BUF -- requirements
Module: spi_rx_pack_buf

Interface
REQ-001 SHALL have parameter AW, default 9, buffer address width (2**AW bytes of storage).
REQ-002 SHALL have port clk  input  1  single clock for all logic (Ethernet client domain).
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port eth_strobe  input  1  qualifies eth_data as a valid payload byte.
REQ-005 SHALL have port eth_data  input  8  UDP payload byte from the Ethernet client.
REQ-006 SHALL have port eth_start  input  1  asserted together with eth_strobe on the first byte of a packet.
REQ-007 SHALL have port eth_commit  input  1  single-cycle pulse: the packet is complete and good.
REQ-008 SHALL have port eth_abort  input  1  single-cycle pulse: discard the packet in progress.
REQ-009 SHALL have port pack_read_ready  output  1  a committed packet is held for the SPI slave.
REQ-010 SHALL have port input_packet_len  output  AW  byte count of the held packet.
REQ-011 SHALL have port pack_read_strobe  input  1  SPI slave consumed the current byte; advance.
REQ-012 SHALL have port pack_data_in  output  8  current read byte.
REQ-013 SHALL have port pack_read_done  input  1  SPI slave finished; release the buffer.
REQ-014 SHALL have port drop_count  output  8  saturating count of discarded packets.

Function
REQ-015 SHALL implement FSM states IDLE, FILL and READY.
REQ-016 IDLE: on eth_strobe&eth_start, SHALL write eth_data to mem[0], set wr_addr=1, clear ovf, and go to FILL.
REQ-017 IDLE: eth_strobe without eth_start, eth_commit and eth_abort SHALL be ignored, with no state change and no count.
REQ-018 FILL: on eth_strobe&~eth_start, SHALL write mem[wr_addr] and increment wr_addr.
REQ-019 FILL: a strobe arriving when wr_addr==2**AW-1 SHALL set ovf and write nothing; further writes SHALL be suppressed until the packet ends.
REQ-020 FILL: on eth_strobe&eth_start, SHALL restart the packet at mem[0] (wr_addr=1, ovf cleared) and increment drop_count.
REQ-021 FILL: on eth_commit with ~ovf and wr_addr!=0, SHALL latch input_packet_len=wr_addr, clear rd_addr and go to READY.
REQ-022 FILL: on eth_commit with ovf set, or on eth_abort, SHALL go to IDLE and increment drop_count.
REQ-023 If eth_commit and eth_strobe occur in the same cycle, the byte SHALL be written first and included in the length.
REQ-024 pack_read_ready SHALL be 1 exactly when the state is READY, registered.
REQ-025 READY: eth_strobe&eth_start SHALL be ignored and increment drop_count once per packet; strobes, commit and abort of that packet SHALL be ignored.
REQ-026 READY: pack_read_strobe SHALL increment rd_addr modulo 2**AW.
REQ-027 pack_data_in SHALL equal mem[rd_addr] one cycle after any rd_addr change, or 8'h00 when rd_addr>=input_packet_len.
REQ-028 On entry to READY, pack_data_in SHALL present mem[0] one cycle later.
REQ-029 READY: pack_read_done SHALL return the FSM to IDLE on the next cycle, deassert pack_read_ready, and reset rd_addr to 0.
REQ-030 pack_read_done and pack_read_strobe outside READY SHALL be ignored.
REQ-031 pack_read_done and eth_start in the same READY cycle: done SHALL take effect, and the start SHALL count as a drop.
REQ-032 drop_count SHALL saturate at 8'hFF.
REQ-033 Storage SHALL be one simple dual-port RAM (one write port, one registered read port) that maps to a block RAM.

Reset
REQ-034 rst SHALL force state=IDLE, pack_read_ready=0, input_packet_len=0, rd_addr=0, wr_addr=0, ovf=0, drop_count=0 and pack_data_in=0 on the next clock edge.
REQ-035 rst SHALL abandon any partial or held packet without counting it as a drop; RAM contents need not be cleared.

Verification
REQ-036 Write 4 bytes 11,22,33,44 (start on the first), then commit: expect pack_read_ready=1, len=4, pack_data_in=11; after 3 pack_read_strobe, 44; after a 4th, 00.
REQ-037 Send pack_read_done in READY: expect pack_read_ready=0 next cycle; a new 2-byte packet AA,BB is then accepted and read back as AA,BB.
REQ-038 Write 512 bytes then commit, with AW=9: expect no READY, drop_count=1; a following 1-byte packet is received normally.
REQ-039 Hold a packet in READY and send a second full packet with commit: expect drop_count+1, held data unchanged, len unchanged.
REQ-040 Assert eth_abort mid-packet, then assert rst mid-FILL: expect IDLE in both cases; drop_count=1 after the abort and 0 after rst.
REQ-041 Force 256 drops: expect drop_count to hold at FF.
